fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues in-order instruction-memory requests, and pairs variable-latency responses with their PCs in a small in-order buffer.
- Delivers {pc, instruction} to decode over a valid/ready handshake.
- Back-pressures the PC register through fetch_stall_po, which drives the PC's halt input.
- Squashes wrong-path fetches on a taken branch.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_buffer.sv | 89 ++++++++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg: shared widths, buffer entry type and clog2 helper      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fetch_pkg;

   localparam int FETCH_XLEN  = 32;
   localparam int FETCH_DEPTH = 2;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] instr;
      logic                  filled;
   } fetch_entry_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_buffer: in-order ring pairing fetch PCs with their responses |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH,
   parameter int XLEN  = FETCH_XLEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc,
   input  logic [XLEN-1:0]       alloc_pc,
   input  logic                  fill,
   input  logic [XLEN-1:0]       fill_data,
   input  logic                  pop,
   input  logic                  flush,
   output logic [clog2(DEPTH):0] count,
   output logic [clog2(DEPTH):0] inflight,
   output logic                  head_valid,
   output logic [XLEN-1:0]       head_pc,
   output logic [XLEN-1:0]       head_instr
);

   localparam int PW = clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t     entries [DEPTH];
   logic [DEPTH-1:0] allocated;
   logic [PW-1:0]    alloc_ptr;
   logic [PW-1:0]    fill_ptr;
   logic [PW-1:0]    head_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         allocated <= '0;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         count     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (flush) begin
         // Only the state bits matter; stale pc/instr are never visible again.
         allocated <= '0;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         count     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i].filled <= 1'b0;
         end
      end else begin
         if (pop) begin
            allocated[head_ptr]      <= 1'b0;
            entries[head_ptr].filled <= 1'b0;
            head_ptr                 <= head_ptr + PW'(1);
         end
         if (alloc) begin
            allocated[alloc_ptr]      <= 1'b1;
            entries[alloc_ptr].pc     <= alloc_pc;
            entries[alloc_ptr].filled <= 1'b0;
            alloc_ptr                 <= alloc_ptr + PW'(1);
         end
         if (fill) begin
            entries[fill_ptr].instr  <= fill_data;
            entries[fill_ptr].filled <= 1'b1;
            fill_ptr                 <= fill_ptr + PW'(1);
         end
         count <= count + CW'(alloc) - CW'(pop);
      end
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < DEPTH; i++) begin
         inflight = inflight + CW'(allocated[i] & ~entries[i].filled);
      end
   end

   assign head_valid = allocated[head_ptr] & entries[head_ptr].filled;
   assign head_pc    = entries[head_ptr].pc;
   assign head_instr = entries[head_ptr].instr;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit: in-order instruction fetch with branch squash          |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH,
   parameter int XLEN  = FETCH_XLEN
) (
   input  logic            clk_pi,
   input  logic            reset_pi,
   input  logic [XLEN-1:0] pc_pi,
   input  logic            isTakenBranch_pi,
   output logic            imem_req_valid_po,
   output logic [XLEN-1:0] imem_req_addr_po,
   input  logic            imem_req_ready_pi,
   input  logic            imem_rsp_valid_pi,
   input  logic [XLEN-1:0] imem_rsp_data_pi,
   output logic            dec_valid_po,
   output logic [XLEN-1:0] dec_pc_po,
   output logic [XLEN-1:0] dec_instr_po,
   input  logic            dec_ready_pi,
   output logic            fetch_stall_po
);

   localparam int CW = clog2(DEPTH) + 1;
   localparam int DW = clog2(2 * DEPTH) + 1;

   logic [CW-1:0] count;
   logic [CW-1:0] inflight;
   logic [DW-1:0] discard;
   logic [DW-1:0] flush_discard;
   logic          accept;
   logic          fill;
   logic          pop;

   // Request gating uses the registered count only, so dec_ready never reaches req_valid.
   assign imem_req_valid_po = ~reset_pi & ~isTakenBranch_pi & (count < CW'(DEPTH));
   assign imem_req_addr_po  = pc_pi;
   assign accept            = imem_req_valid_po & imem_req_ready_pi;
   assign fetch_stall_po    = ~accept;

   assign fill = imem_rsp_valid_pi & ~isTakenBranch_pi & (discard == '0) & (inflight != '0);
   assign pop  = dec_valid_po & dec_ready_pi & ~isTakenBranch_pi;

   fetch_buffer #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) u_buffer (
      .clk        (clk_pi),
      .rst        (reset_pi),
      .alloc      (accept),
      .alloc_pc   (pc_pi),
      .fill       (fill),
      .fill_data  (imem_rsp_data_pi),
      .pop        (pop),
      .flush      (isTakenBranch_pi),
      .count      (count),
      .inflight   (inflight),
      .head_valid (dec_valid_po),
      .head_pc    (dec_pc_po),
      .head_instr (dec_instr_po)
   );

   // A response landing on the flush edge belongs to the old path and is consumed here.
   always_comb begin
      flush_discard = discard + DW'(inflight);
      if (imem_rsp_valid_pi && (flush_discard != '0)) begin
         flush_discard = flush_discard - DW'(1);
      end
   end

   always_ff @(posedge clk_pi or posedge reset_pi) begin
      if (reset_pi) begin
         discard <= '0;
      end else if (isTakenBranch_pi) begin
         discard <= flush_discard;
      end else if (imem_rsp_valid_pi && (discard != '0)) begin
         discard <= discard - DW'(1);
      end
   end

   a_no_orphan_rsp : assert property (@(posedge clk_pi) disable iff (reset_pi)
      !(imem_rsp_valid_pi && !isTakenBranch_pi && (discard == '0) && (inflight == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_unit: randomized bench with queue-based reference model   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fetch_unit;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] pc;
   logic            taken;
   logic [XLEN-1:0] target;
   logic            req_valid;
   logic [XLEN-1:0] req_addr;
   logic            req_ready;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_data;
   logic            dec_valid;
   logic [XLEN-1:0] dec_pc;
   logic [XLEN-1:0] dec_instr;
   logic            dec_ready;
   logic            stall;

   always #5 clk = ~clk;

   fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk_pi            (clk),
      .reset_pi          (rst),
      .pc_pi             (pc),
      .isTakenBranch_pi  (taken),
      .imem_req_valid_po (req_valid),
      .imem_req_addr_po  (req_addr),
      .imem_req_ready_pi (req_ready),
      .imem_rsp_valid_pi (rsp_valid),
      .imem_rsp_data_pi  (rsp_data),
      .dec_valid_po      (dec_valid),
      .dec_pc_po         (dec_pc),
      .dec_instr_po      (dec_instr),
      .dec_ready_pi      (dec_ready),
      .fetch_stall_po    (stall)
   );

   typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;

   ent_t        buf_q[$];
   mreq_t       mem_q[$];
   logic [31:0] decoded[$];
   int          discard_m;
   int          cyc;
   int          n_cmp;
   int          n_fail;
   int          acc_seen;
   int          lat_min;
   int          lat_max;
   logic [98:0] obs;
   logic [98:0] expv;
   logic        o_req_valid;
   logic        o_stall;
   logic [31:0] o_addr;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
   endfunction

   // One clock: drive memory response, sample outputs, predict, advance model and environment.
   task automatic step();
      bit          acc;
      bit          ev;
      bit          exp_req;
      bit          done;
      int          unf;
      logic [31:0] pc_next;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         rsp_valid = 1'b1;
         rsp_data  = instr_of(mem_q[0].addr);
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = $urandom;
      end
      #1;
      ev      = buf_q.size() > 0 && buf_q[0].filled;
      exp_req = !taken && buf_q.size() < DEPTH;
      acc     = exp_req && req_ready;
      expv = {exp_req, !acc, ev, exp_req ? pc : 32'h0,
              ev ? buf_q[0].pc : 32'h0, ev ? buf_q[0].instr : 32'h0};
      obs  = {req_valid, stall, dec_valid, req_valid ? req_addr : 32'h0,
              dec_valid ? dec_pc : 32'h0, dec_valid ? dec_instr : 32'h0};
      o_req_valid = req_valid;
      o_stall     = stall;
      o_addr      = req_addr;
      // Environment reacts to what the DUT actually did.
      if (req_valid === 1'b1 && req_ready) begin
         acc_seen++;
         mem_q.push_back('{req_addr, cyc + $urandom_range(lat_max, lat_min)});
      end
      if (dec_valid === 1'b1 && dec_ready && !taken) decoded.push_back(dec_pc);
      pc_next = taken ? target : (stall === 1'b0 ? pc + 32'd4 : pc);
      if (rsp_valid) void'(mem_q.pop_front());
      // Reference model.
      if (taken) begin
         unf = 0;
         foreach (buf_q[i]) if (!buf_q[i].filled) unf++;
         discard_m = discard_m + unf - (rsp_valid ? 1 : 0);
         buf_q.delete();
      end else begin
         if (rsp_valid) begin
            if (discard_m > 0) begin
               discard_m--;
            end else begin
               done = 1'b0;
               foreach (buf_q[i]) begin
                  if (!done && !buf_q[i].filled) begin
                     buf_q[i].filled = 1'b1;
                     buf_q[i].instr  = rsp_data;
                     done = 1'b1;
                  end
               end
            end
         end
         if (ev && dec_ready) void'(buf_q.pop_front());
         if (acc) buf_q.push_back('{pc, 32'h0, 1'b0});
      end
      cyc++;
      @(negedge clk);
      pc = pc_next;
   endtask

   task automatic apply_reset();
      rst = 1'b1; taken = 1'b0; target = '0; req_ready = 1'b0;
      dec_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
      @(negedge clk);
      @(negedge clk);
      buf_q.delete(); mem_q.delete(); decoded.delete();
      discard_m = 0; pc = '0;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; taken = 1'b0; req_ready = 1'b0; dec_ready = 1'b0; rsp_valid = 1'b0; pc = '0;
      #1;
      n_cmp++;
      if ({req_valid, stall, dec_valid} !== 3'b010) begin
         n_fail++;
         $display("FAIL reset_outputs got %b want 010", {req_valid, stall, dec_valid});
      end
      apply_reset();
      step();
      n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL reset_first got %h want %h", obs, expv); end
   endtask

   task automatic test_zero_wait();
      apply_reset();
      lat_min = 1; lat_max = 1; req_ready = 1'b1; dec_ready = 1'b1;
      repeat (16) begin
         step();
         n_cmp++;
         if (obs !== expv) begin n_fail++; $display("FAIL zero_wait cyc=%0d got %h want %h", cyc, obs, expv); end
      end
      n_cmp++;
      if (decoded.size() < 5) begin n_fail++; $display("FAIL zero_wait_count got %0d want >=5", decoded.size()); end
      foreach (decoded[i]) begin
         n_cmp++;
         if (decoded[i] !== 32'(4 * i)) begin
            n_fail++; $display("FAIL zero_wait_seq[%0d] got %h want %h", i, decoded[i], 4 * i);
         end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      lat_min = 1; lat_max = 1; req_ready = 1'b1; dec_ready = 1'b0; acc_seen = 0;
      repeat (6) begin
         step();
         n_cmp++;
         if (obs !== expv) begin n_fail++; $display("FAIL backpressure cyc=%0d got %h want %h", cyc, obs, expv); end
      end
      n_cmp++;
      if (acc_seen != DEPTH) begin n_fail++; $display("FAIL full_accepts got %0d want %0d", acc_seen, DEPTH); end
      n_cmp++;
      if ({o_req_valid, o_stall} !== 2'b01) begin
         n_fail++; $display("FAIL full_hold got %b want 01", {o_req_valid, o_stall});
      end
      dec_ready = 1'b1;
      repeat (12) begin
         step();
         n_cmp++;
         if (obs !== expv) begin n_fail++; $display("FAIL resume cyc=%0d got %h want %h", cyc, obs, expv); end
      end
      n_cmp++;
      if (decoded.size() < 4) begin n_fail++; $display("FAIL resume_count got %0d want >=4", decoded.size()); end
      foreach (decoded[i]) begin
         n_cmp++;
         if (decoded[i] !== 32'(4 * i)) begin
            n_fail++; $display("FAIL resume_seq[%0d] got %h want %h", i, decoded[i], 4 * i);
         end
      end
   endtask

   task automatic test_req_hold();
      apply_reset();
      lat_min = 1; lat_max = 1; dec_ready = 1'b1; req_ready = 1'b1;
      taken = 1'b1; target = 32'h10;
      step();
      taken = 1'b0; req_ready = 1'b0;
      repeat (3) begin
         step();
         n_cmp++;
         if ({o_req_valid, o_stall, o_addr} !== {2'b11, 32'h10}) begin
            n_fail++; $display("FAIL req_hold got %b/%b/%h want 1/1/00000010", o_req_valid, o_stall, o_addr);
         end
      end
      req_ready = 1'b1;
      step();
      n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL req_hold_accept got %h want %h", obs, expv); end
      step();
      n_cmp++;
      if ({o_req_valid, o_addr} !== {1'b1, 32'h14}) begin
         n_fail++; $display("FAIL req_next got %b/%h want 1/00000014", o_req_valid, o_addr);
      end
   endtask

   task automatic test_flush_inflight();
      apply_reset();
      lat_min = 4; lat_max = 4; req_ready = 1'b1; dec_ready = 1'b1;
      taken = 1'b1; target = 32'h20;
      step();
      taken = 1'b0;
      repeat (2) begin
         step();
         n_cmp++;
         if (obs !== expv) begin n_fail++; $display("FAIL inflight_issue got %h want %h", obs, expv); end
      end
      taken = 1'b1; target = 32'h100;
      step();
      taken = 1'b0; lat_min = 1; lat_max = 1; decoded.delete();
      repeat (14) begin
         step();
         n_cmp++;
         if (obs !== expv) begin n_fail++; $display("FAIL after_flush cyc=%0d got %h want %h", cyc, obs, expv); end
      end
      n_cmp++;
      if (decoded.size() < 2 || decoded[0] !== 32'h100 || decoded[1] !== 32'h104) begin
         n_fail++;
         $display("FAIL flush_first_pc got %h want 00000100 (n=%0d)", decoded.size() > 0 ? decoded[0] : 32'hx, decoded.size());
      end
   endtask

   task automatic test_flush_collision();
      bit found;
      apply_reset();
      lat_min = 1; lat_max = 1; req_ready = 1'b1; dec_ready = 1'b1; found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (mem_q.size() > 0 && mem_q[0].due <= cyc && buf_q.size() > 0 && buf_q[0].filled) begin
            found = 1'b1;
         end else begin
            step();
            n_cmp++;
            if (obs !== expv) begin n_fail++; $display("FAIL collide_setup got %h want %h", obs, expv); end
         end
      end
      n_cmp++;
      if (!found) begin n_fail++; $display("FAIL collide_search got 0 want 1"); end
      taken = 1'b1; target = 32'h200;
      step();
      n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL collide_flush1 got %h want %h", obs, expv); end
      target = 32'h300;
      step();
      n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL collide_flush2 got %h want %h", obs, expv); end
      taken = 1'b0; decoded.delete();
      repeat (12) begin
         step();
         n_cmp++;
         if (obs !== expv) begin n_fail++; $display("FAIL collide_after cyc=%0d got %h want %h", cyc, obs, expv); end
      end
      n_cmp++;
      if (decoded.size() < 1 || decoded[0] !== 32'h300) begin
         n_fail++; $display("FAIL collide_first_pc got %h want 00000300", decoded.size() > 0 ? decoded[0] : 32'hx);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      lat_min = 1; lat_max = 1; req_ready = 1'b1; dec_ready = 1'b1;
      repeat (6) begin
         step();
         n_cmp++;
         if (obs !== expv) begin n_fail++; $display("FAIL burst cyc=%0d got %h want %h", cyc, obs, expv); end
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({req_valid, stall, dec_valid} !== 3'b010) begin
         n_fail++; $display("FAIL async_reset got %b want 010", {req_valid, stall, dec_valid});
      end
      @(negedge clk);
      @(negedge clk);
      buf_q.delete(); mem_q.delete(); decoded.delete();
      discard_m = 0; pc = '0; rsp_valid = 1'b0;
      rst = 1'b0;
      repeat (10) begin
         step();
         n_cmp++;
         if (obs !== expv) begin n_fail++; $display("FAIL post_reset cyc=%0d got %h want %h", cyc, obs, expv); end
      end
      n_cmp++;
      if (decoded.size() < 1 || decoded[0] !== 32'h0) begin
         n_fail++; $display("FAIL restart_pc got %h want 00000000", decoded.size() > 0 ? decoded[0] : 32'hx);
      end
   endtask

   task automatic test_random();
      apply_reset();
      lat_min = 1; lat_max = 4;
      repeat (3000) begin
         req_ready = ($urandom_range(99, 0) < 70);
         dec_ready = ($urandom_range(99, 0) < 70);
         taken     = ($urandom_range(99, 0) < 8);
         target    = $urandom & 32'hFFFF_FFFC;
         step();
         n_cmp++;
         if (obs !== expv) begin n_fail++; $display("FAIL random cyc=%0d got %h want %h", cyc, obs, expv); end
      end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0; cyc = 0; acc_seen = 0; discard_m = 0;
      lat_min = 1; lat_max = 1;
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_req_hold();
      test_flush_inflight();
      test_flush_collision();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
